divider_datapath: RTL



---
 rtl/divider_pkg.sv | 26 ++
 rtl/divider_cmp_sub.sv | 19 +
 rtl/divider_datapath.sv | 112 +++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the repeated-subtraction divider (datapath, control path, bench).
package divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Control actions, listed in priority order: LOAD > EVAL > UPDATE > IDLE.
  // Reset sits above all of these and is handled directly by the registers.
  typedef enum logic [1:0] {
    ACT_IDLE   = 2'd0,
    ACT_LOAD   = 2'd1,
    ACT_EVAL   = 2'd2,
    ACT_UPDATE = 2'd3
  } ctrl_action_e;

  // Reduce the raw control strobes to the single action that takes effect.
  function automatic ctrl_action_e decode_action(input logic ld, input logic ld2,
                                                 input logic cng);
    ctrl_action_e act;
    if (ld)       act = ACT_LOAD;
    else if (ld2) act = ACT_EVAL;
    else if (cng) act = ACT_UPDATE;
    else          act = ACT_IDLE;
    return act;
  endfunction

endpackage

// File: rtl/divider_cmp_sub.sv
// Combinational compare / zero-check / subtract slice of the divider datapath.
module divider_cmp_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_ge_b_c,
  output logic             b_nz_c,
  output logic [WIDTH-1:0] diff_c
);

  // A >= B decides whether another subtraction fits; B != 0 guards divide-by-zero.
  always_comb begin
    a_ge_b_c = (a >= b);
    b_nz_c   = (b != '0);
    diff_c   = a - b;
  end

endmodule

// File: rtl/divider_datapath.sv
// Registered datapath for the repeated-subtraction unsigned divider.
module divider_datapath
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             ld2,
  input  logic             cng,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             upd,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             dbz
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             cmp_q, cmp_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             a_ge_b_c;
  logic             b_nz_c;
  logic [WIDTH-1:0] diff_c;
  ctrl_action_e     act_c;

  divider_cmp_sub #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a       (a_q),
    .b       (b_q),
    .a_ge_b_c(a_ge_b_c),
    .b_nz_c  (b_nz_c),
    .diff_c  (diff_c)
  );

  // Status to the control path: another subtraction is still needed.
  always_comb begin
    upd   = b_nz_c && a_ge_b_c && !done_q;
    act_c = decode_action(ld, ld2, cng);
  end

  // Next-state: only the highest-priority action applies; a finished result stays frozen.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    q_d    = q_q;
    cmp_d  = cmp_q;
    done_d = done_q;
    dbz_d  = dbz_q;
    case (act_c)
      ACT_LOAD: begin
        a_d    = dividend;
        b_d    = divisor;
        q_d    = '0;
        cmp_d  = 1'b0;
        done_d = 1'b0;
        dbz_d  = (divisor == '0);
      end
      ACT_EVAL: begin
        if (!done_q) begin
          cmp_d = upd;
          if (!upd) done_d = 1'b1;
          if (dbz_q) q_d = '1;
        end
      end
      ACT_UPDATE: begin
        // Only subtract after a true compare, so A can never underflow.
        if (cmp_q && !done_q) begin
          a_d   = diff_c;
          q_d   = q_q + WIDTH'(1);
          cmp_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      q_q    <= '0;
      cmp_q  <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      q_q    <= q_d;
      cmp_q  <= cmp_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
    end
  end

  // Registered results straight from the working registers.
  always_comb begin
    quotient  = q_q;
    remainder = a_q;
    done      = done_q;
    dbz       = dbz_q;
  end

endmodule
